mrd_sink_pack_p4: RTL and testbench

- Upstream feeder for the 4-lane mixed-radix DFT core.
- Accepts a serial complex stream, one sample per cycle, with valid/ready/sop/eop framing.
- Packs 4 consecutive samples into one 4-lane word for the core's sink interface (sink_valid/sink_ready/sink_sop/sink_eop/sink_real[0:3]/sink_imag[0:3]/size).
- Latches the frame's size code at sop and flags framing errors.

---
 rtl/mrd_pack_pkg.sv | 23 ++
 rtl/mrd_pack_fifo.sv | 95 +++++++++
 rtl/mrd_sink_pack_p4.sv | 200 ++++++++++++++++++++
 tb/tb_mrd_sink_pack_p4.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrd_pack_pkg.sv
// Shared types and constants for the 4-lane sink packer feeding the
// mixed-radix DFT core.
package mrd_pack_pkg;

    localparam int DW = 18;   // sample real/imag width
    localparam int NL = 4;    // lanes per packed word
    localparam int SW = 6;    // DFT size code width

    // One packed word as held in the output buffer; lane 0 is the earliest sample.
    typedef struct packed {
        logic [NL-1:0][DW-1:0] re;
        logic [NL-1:0][DW-1:0] im;
        logic                  sop;
        logic                  eop;
        logic [SW-1:0]         size;
    } pack_word_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } pack_state_e;

endpackage

// File: rtl/mrd_pack_fifo.sv
// Small FIFO of packed words with registered empty/full flags.
// Reads are from the head entry directly, so the head stays stable until popped.
module mrd_pack_fifo
    import mrd_pack_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  pack_word_t wr_data_i,
    input  logic       pop_i,
    output pack_word_t rd_data_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    pack_word_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          empty_q, full_q;
    logic          do_push_s, do_pop_s;

    // Pointer advance with wrap at the last entry.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1);
        end
    endfunction

    // Next-state for pointers and occupancy; overflow/underflow requests are ignored.
    always_comb begin
        do_push_s = push_i & ~full_q;
        do_pop_s  = pop_i & ~empty_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (do_push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= (cnt_d == {CW{1'b0}});
            full_q   <= (cnt_d == CW'(DEPTH));
        end
    end

    // Storage; cleared on reset so the idle output lanes read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = empty_q;
    assign full_o    = full_q;

endmodule

// File: rtl/mrd_sink_pack_p4.sv
// Serial-to-4-lane packer in front of the mixed-radix DFT core sink port.
// Optional statistics counters are enabled with `define MRD_SINK_PACK_STAT_EN.
module mrd_sink_pack_p4
    import mrd_pack_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sop,
    input  logic          in_eop,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    input  logic [SW-1:0] in_size,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sop,
    output logic          out_eop,
    output logic [DW-1:0] out_real [0:NL-1],
    output logic [DW-1:0] out_imag [0:NL-1],
    output logic [SW-1:0] out_size,
`ifdef MRD_SINK_PACK_STAT_EN
    output logic [15:0]   frame_cnt,
    output logic [7:0]    err_cnt,
`endif
    output logic          err_pulse
);

    pack_state_e           state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [NL-1:0][DW-1:0] re_q, re_d, im_q, im_d;
    logic [NL-1:0][DW-1:0] lane_re_s, lane_im_s;
    logic                  psop_q, psop_d;
    logic [SW-1:0]         size_q, size_d;
    logic                  err_q, err_d;
    logic                  rdy_q;
    logic                  beat_s, push_s, pop_s;
    logic                  empty_s, full_s;
    pack_word_t            word_s, head_s;

    assign beat_s = in_valid & in_ready;
    assign pop_s  = out_valid & out_ready;

    // Framing FSM: assembles lanes, decides pushes and flags framing errors.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        re_d      = re_q;
        im_d      = im_q;
        psop_d    = psop_q;
        size_d    = size_q;
        err_d     = 1'b0;
        push_s    = 1'b0;
        word_s    = '0;
        lane_re_s = re_q;
        lane_im_s = im_q;
        if (beat_s) begin
            if (in_sop) begin
                // A sop always restarts at lane 0; any partial word is dropped.
                lane_re_s    = '0;
                lane_im_s    = '0;
                lane_re_s[0] = in_real;
                lane_im_s[0] = in_imag;
                size_d       = in_size;
                err_d        = (state_q == FILL) | in_eop;
                if (in_eop) begin
                    push_s      = 1'b1;
                    word_s.re   = lane_re_s;
                    word_s.im   = lane_im_s;
                    word_s.sop  = 1'b1;
                    word_s.eop  = 1'b1;
                    word_s.size = in_size;
                    re_d        = '0;
                    im_d        = '0;
                    psop_d      = 1'b0;
                    cnt_d       = 2'd0;
                    state_d     = IDLE;
                end else begin
                    re_d    = lane_re_s;
                    im_d    = lane_im_s;
                    psop_d  = 1'b1;
                    cnt_d   = 2'd1;
                    state_d = FILL;
                end
            end else if (state_q == FILL) begin
                lane_re_s[cnt_q] = in_real;
                lane_im_s[cnt_q] = in_imag;
                if (in_eop || (cnt_q == 2'd3)) begin
                    push_s      = 1'b1;
                    word_s.re   = lane_re_s;
                    word_s.im   = lane_im_s;
                    word_s.sop  = psop_q;
                    word_s.eop  = in_eop;
                    word_s.size = size_q;
                    re_d        = '0;
                    im_d        = '0;
                    psop_d      = 1'b0;
                    cnt_d       = 2'd0;
                    if (in_eop) begin
                        // Frame length not a multiple of 4 is a pad error.
                        state_d = IDLE;
                        err_d   = (cnt_q != 2'd3);
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    re_d  = lane_re_s;
                    im_d  = lane_im_s;
                    cnt_d = cnt_q + 2'd1;
                end
            end else begin
                // Sample outside any frame is dropped.
                err_d = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Framing state, lane buffer, size latch and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            re_q    <= '0;
            im_q    <= '0;
            psop_q  <= 1'b0;
            size_q  <= {SW{1'b0}};
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            re_q    <= re_d;
            im_q    <= im_d;
            psop_q  <= psop_d;
            size_q  <= size_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

    mrd_pack_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push_s),
        .wr_data_i (word_s),
        .pop_i     (pop_s),
        .rd_data_o (head_s),
        .empty_o   (empty_s),
        .full_o    (full_s)
    );

    assign in_ready  = rdy_q & ~full_s;
    assign out_valid = ~empty_s;
    assign out_sop   = head_s.sop;
    assign out_eop   = head_s.eop;
    assign out_size  = size_q;
    assign err_pulse = err_q;

    // Unpack the head word onto the lane arrays.
    always_comb begin
        for (int i = 0; i < NL; i++) begin
            out_real[i] = head_s.re[i];
            out_imag[i] = head_s.im[i];
        end
    end

`ifdef MRD_SINK_PACK_STAT_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  err_cnt_q;

    // Completed-frame counter (wrapping) and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 8'd0;
        end else begin
            if (pop_s && head_s.eop) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
                frame_cnt_q <= frame_cnt_q;
            end
            if (err_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end else begin
                err_cnt_q <= err_cnt_q;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_mrd_sink_pack_p4.sv
// Randomized self-checking bench for mrd_sink_pack_p4 against a
// queue-based frame model.
module tb_mrd_sink_pack_p4;

    localparam int DW  = 18;
    localparam int NL  = 4;
    localparam int SW  = 6;
    localparam int BUF = 2;

    typedef struct {
        logic          sop;
        logic          eop;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [SW-1:0] size;
    } beat_t;

    typedef struct packed {
        logic [NL-1:0][DW-1:0] re;
        logic [NL-1:0][DW-1:0] im;
        logic                  sop;
        logic                  eop;
    } exp_w_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic [DW-1:0] in_real = '0, in_imag = '0;
    logic [SW-1:0] in_size = '0;
    logic          in_ready, out_valid, out_sop, out_eop, err_pulse;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_real [0:NL-1];
    logic [DW-1:0] out_imag [0:NL-1];
    logic [SW-1:0] out_size;
`ifdef MRD_SINK_PACK_STAT_EN
    logic [15:0]   frame_cnt;
    logic [7:0]    err_cnt;
`endif

    mrd_sink_pack_p4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .in_size   (in_size),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_size  (out_size),
`ifdef MRD_SINK_PACK_STAT_EN
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
`endif
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

    int      n_checks = 0;
    int      n_fail   = 0;

    // Stimulus and model state
    beat_t   stim_q[$];
    exp_w_t  exp_q[$];
    beat_t   m_cur[$];
    bit      m_active = 1'b0;
    bit      m_first  = 1'b0;
    logic [SW-1:0] m_size = '0;
    bit      exp_err  = 1'b0;
    bit      exp_rdy_en = 1'b0;
    int      m_frames = 0;
    int      m_errs   = 0;
    int      vprob    = 100;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic add_frame(input int len, input logic [SW-1:0] sz, input bit with_eop);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.sop  = (i == 0);
            b.eop  = with_eop && (i == len - 1);
            b.re   = DW'($urandom);
            b.im   = DW'($urandom);
            b.size = sz;
            stim_q.push_back(b);
        end
    endtask

    // Emit the current partial word, zero-padding missing lanes.
    task automatic model_emit(input bit eop);
        exp_w_t w;
        w = '0;
        for (int i = 0; i < NL; i++) begin
            if (i < m_cur.size()) begin
                w.re[i] = m_cur[i].re;
                w.im[i] = m_cur[i].im;
            end
        end
        w.sop = m_first;
        w.eop = eop;
        m_first = 1'b0;
        m_cur.delete();
        exp_q.push_back(w);
    endtask

    task automatic model_beat(input beat_t b, output bit err);
        err = 1'b0;
        if (b.sop) begin
            if (m_active) err = 1'b1;
            m_cur.delete();
            m_cur.push_back(b);
            m_active = 1'b1;
            m_first  = 1'b1;
            m_size   = b.size;
            if (b.eop) begin
                err = 1'b1;
                model_emit(1'b1);
                m_active = 1'b0;
            end
        end else if (!m_active) begin
            err = 1'b1;
        end else begin
            m_cur.push_back(b);
            if (b.eop) begin
                if (m_cur.size() != NL) err = 1'b1;
                model_emit(1'b1);
                m_active = 1'b0;
            end else if (m_cur.size() == NL) begin
                model_emit(1'b0);
            end
        end
    endtask

    // One clock per iteration, starting and ending at a falling edge.
    // rmode: 0 ready high, 1 random, 2 low for first 10 cycles, 3 low always.
    task automatic run_cycles(input int max_cyc, input int rmode, input bit until_drained);
        bit done;
        bit e;
        beat_t b;
        logic [NL-1:0][DW-1:0] g_re, g_im;
        done = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            if (until_drained && stim_q.size() == 0 && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            chk("err_pulse", 96'(err_pulse), 96'(exp_err));
            chk("out_size", 96'(out_size), 96'(m_size));
            chk("out_valid", 96'(out_valid), 96'(exp_q.size() != 0));
            if (exp_rdy_en) chk("in_ready", 96'(in_ready), 96'(exp_q.size() < BUF));
            if (out_valid && exp_q.size() != 0) begin
                for (int i = 0; i < NL; i++) begin
                    g_re[i] = out_real[i];
                    g_im[i] = out_imag[i];
                end
                chk("word_re", 96'(g_re), 96'(exp_q[0].re));
                chk("word_im", 96'(g_im), 96'(exp_q[0].im));
                chk("word_sop_eop", 96'({out_sop, out_eop}), 96'({exp_q[0].sop, exp_q[0].eop}));
            end
            in_valid = (stim_q.size() != 0) && ($urandom_range(0, 99) < vprob);
            if (stim_q.size() != 0) begin
                in_sop  = stim_q[0].sop;
                in_eop  = stim_q[0].eop;
                in_real = stim_q[0].re;
                in_imag = stim_q[0].im;
                in_size = stim_q[0].size;
            end else begin
                in_sop  = 1'b0;
                in_eop  = 1'b0;
                in_real = DW'($urandom);
                in_imag = DW'($urandom);
                in_size = SW'($urandom);
            end
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 99) < 60);
                2: out_ready = (k >= 10);
                default: out_ready = 1'b0;
            endcase
            #1;
            if (out_valid && out_ready && exp_q.size() != 0) begin
                if (exp_q[0].eop) m_frames++;
                void'(exp_q.pop_front());
            end
            exp_err = 1'b0;
            if (in_valid && in_ready) begin
                b = stim_q.pop_front();
                model_beat(b, e);
                exp_err = e;
                if (e && m_errs < 255) m_errs++;
            end
            @(posedge clk);
            exp_rdy_en = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (until_drained && !done) begin
            done = (stim_q.size() == 0 && exp_q.size() == 0);
            chk("drain_timeout", 96'(done), 96'(1));
        end
    endtask

    task automatic model_reset();
        stim_q.delete();
        exp_q.delete();
        m_cur.delete();
        m_active   = 1'b0;
        m_first    = 1'b0;
        m_size     = '0;
        exp_err    = 1'b0;
        exp_rdy_en = 1'b0;
        m_frames   = 0;
        m_errs     = 0;
    endtask

    initial begin
        beat_t sb;
        // Reset state
        #12;
        chk("rst_out_valid", 96'(out_valid), 96'(0));
        chk("rst_in_ready", 96'(in_ready), 96'(0));
        chk("rst_err", 96'(err_pulse), 96'(0));
        chk("rst_size", 96'(out_size), 96'(0));
        chk("rst_lanes", 96'({out_real[0], out_real[3], out_imag[0], out_imag[3]}), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 12-sample frame, full-rate output
        add_frame(12, 6'd5, 1'b1);
        run_cycles(200, 0, 1'b1);
        // Same shape with 10 cycles of back-pressure
        add_frame(12, 6'd5, 1'b1);
        run_cycles(200, 2, 1'b1);
        // 6-sample frame with pad error
        add_frame(6, 6'd7, 1'b1);
        run_cycles(200, 0, 1'b1);
        // Abort after 2 samples, then a new frame with its own size
        add_frame(2, 6'd11, 1'b0);
        add_frame(8, 6'd9, 1'b1);
        run_cycles(200, 0, 1'b1);
        // Stray beat outside a frame
        sb.sop = 1'b0; sb.eop = 1'b0; sb.re = 18'h1234; sb.im = 18'h0; sb.size = 6'd3;
        stim_q.push_back(sb);
        run_cycles(50, 0, 1'b1);
        // Single-beat frame
        add_frame(1, 6'd2, 1'b1);
        run_cycles(50, 0, 1'b1);

        // Random frames with random gaps and back-pressure
        vprob = 75;
        for (int f = 0; f < 150; f++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                sb.sop = 1'b0; sb.eop = 1'($urandom); sb.re = DW'($urandom);
                sb.im = DW'($urandom); sb.size = SW'($urandom);
                stim_q.push_back(sb);
            end else begin
                add_frame($urandom_range(1, 13), SW'($urandom), r != 1);
            end
        end
        run_cycles(20000, 1, 1'b1);
        // Finish the last frame cleanly before checking counters
        add_frame(4, 6'd1, 1'b1);
        run_cycles(200, 0, 1'b1);
`ifdef MRD_SINK_PACK_STAT_EN
        chk("frame_cnt", 96'(frame_cnt), 96'(m_frames));
        chk("err_cnt", 96'(err_cnt), 96'(m_errs));
`endif

        // Asynchronous reset with a word buffered and a partial word pending
        vprob = 100;
        add_frame(7, 6'd13, 1'b1);
        run_cycles(6, 3, 1'b0);
        chk("pre_rst_valid", 96'(out_valid), 96'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 96'(out_valid), 96'(0));
        chk("async_rst_ready", 96'(in_ready), 96'(0));
        chk("async_rst_lane0", 96'(out_real[0]), 96'(0));
        chk("async_rst_size", 96'(out_size), 96'(0));
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        add_frame(8, 6'd4, 1'b1);
        run_cycles(200, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
